// File: rtl/window_mcu.sv
// window_mcu - main control unit of the edge-detection datapath.
//
// Walks a WIN x WIN window over an IMG_W x IMG_H image (row-major, stride 1,
// no padding). For every window it issues WIN*WIN reads (tap column first,
// then tap row), pulses the compute stage once, writes one result and moves
// to the next window. Addresses are tracked incrementally, so there are no
// multipliers.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   i_start           start/restart a frame (taken in IDLE and DONE)
//   i_stop            pause request, honoured only between windows
//   i_read_complete   read handshake, accepted only while waiting for a read
//   i_calc_ready      compute handshake, accepted only while waiting on compute
//   i_write_complete  write handshake, accepted only while waiting for a write
//   o_raddr / o_re    read address and 1-cycle read strobe
//   o_calc_start      1-cycle compute start pulse
//   o_waddr / o_we    write address and 1-cycle write strobe
//   o_complete        frame finished (level, held until the next start)
//   o_busy_cycles     only with WINDOW_MCU_PERF_EN: saturating count of
//                     cycles spent actively working on the frame
//
// Optional feature macro: WINDOW_MCU_PERF_EN

module window_mcu #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int WIN    = 3,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_RADDR = '0,
  parameter logic [ADDR_W-1:0] BASE_WADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_read_complete,
  input  logic              i_calc_ready,
  input  logic              i_write_complete,
`ifdef WINDOW_MCU_PERF_EN
  output logic [31:0]       o_busy_cycles,
`endif
  output logic [ADDR_W-1:0] o_raddr,
  output logic              o_re,
  output logic              o_calc_start,
  output logic [ADDR_W-1:0] o_waddr,
  output logic              o_we,
  output logic              o_complete
);

  localparam int OUT_W = IMG_W - WIN + 1;
  localparam int OUT_H = IMG_H - WIN + 1;
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int TAP_W = (WIN > 1) ? $clog2(WIN) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(WIN - 1);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_RD_ISSUE   = 4'd1;
  localparam logic [3:0] S_RD_WAIT    = 4'd2;
  localparam logic [3:0] S_CALC_START = 4'd3;
  localparam logic [3:0] S_CALC_WAIT  = 4'd4;
  localparam logic [3:0] S_WR_ISSUE   = 4'd5;
  localparam logic [3:0] S_WR_WAIT    = 4'd6;
  localparam logic [3:0] S_ADVANCE    = 4'd7;
  localparam logic [3:0] S_PAUSE      = 4'd8;
  localparam logic [3:0] S_DONE       = 4'd9;

  logic [3:0]        state;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [TAP_W-1:0]  tap_r;
  logic [TAP_W-1:0]  tap_c;
  logic [ADDR_W-1:0] win_raddr;   // read address of tap (0,0) of the window
  logic [ADDR_W-1:0] tap_raddr;   // read address of the current tap
  logic [ADDR_W-1:0] win_waddr;   // result address of the current window
  logic [ADDR_W-1:0] nxt_win_raddr;
  logic              last_win;
  logic              frame_start;

  // Moving one window right adds 1; wrapping to the next window row jumps
  // from col OUT_W-1 to col 0 one image row down, i.e. IMG_W-(OUT_W-1) = WIN.
  assign nxt_win_raddr = (col == COL_LAST) ? win_raddr + ADDR_W'(WIN)
                                           : win_raddr + ADDR_W'(1);
  assign last_win      = (row == ROW_LAST) && (col == COL_LAST);
  assign frame_start   = ((state == S_IDLE) && i_start && !i_stop) ||
                         ((state == S_DONE) && i_start);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      row          <= '0;
      col          <= '0;
      tap_r        <= '0;
      tap_c        <= '0;
      win_raddr    <= BASE_RADDR;
      tap_raddr    <= BASE_RADDR;
      win_waddr    <= BASE_WADDR;
      o_raddr      <= '0;
      o_re         <= 1'b0;
      o_calc_start <= 1'b0;
      o_waddr      <= '0;
      o_we         <= 1'b0;
      o_complete   <= 1'b0;
    end else begin
      o_re         <= 1'b0;
      o_calc_start <= 1'b0;
      o_we         <= 1'b0;
      if (frame_start) begin
        row        <= '0;
        col        <= '0;
        tap_r      <= '0;
        tap_c      <= '0;
        win_raddr  <= BASE_RADDR;
        tap_raddr  <= BASE_RADDR;
        win_waddr  <= BASE_WADDR;
        o_complete <= 1'b0;
        state      <= S_RD_ISSUE;
      end else begin
        case (state)
          S_RD_ISSUE: begin
            o_raddr <= tap_raddr;
            o_re    <= 1'b1;
            state   <= S_RD_WAIT;
          end
          S_RD_WAIT: begin
            if (i_read_complete) begin
              if ((tap_r == TAP_LAST) && (tap_c == TAP_LAST)) begin
                tap_r <= '0;
                tap_c <= '0;
                state <= S_CALC_START;
              end else if (tap_c == TAP_LAST) begin
                // Next tap row: back WIN-1 columns, down one image row.
                tap_c     <= '0;
                tap_r     <= tap_r + TAP_W'(1);
                tap_raddr <= tap_raddr + ADDR_W'(OUT_W);
                state     <= S_RD_ISSUE;
              end else begin
                tap_c     <= tap_c + TAP_W'(1);
                tap_raddr <= tap_raddr + ADDR_W'(1);
                state     <= S_RD_ISSUE;
              end
            end
          end
          S_CALC_START: begin
            o_calc_start <= 1'b1;
            state        <= S_CALC_WAIT;
          end
          S_CALC_WAIT: begin
            if (i_calc_ready) state <= S_WR_ISSUE;
          end
          S_WR_ISSUE: begin
            o_waddr <= win_waddr;
            o_we    <= 1'b1;
            state   <= S_WR_WAIT;
          end
          S_WR_WAIT: begin
            if (i_write_complete) state <= S_ADVANCE;
          end
          S_ADVANCE: begin
            if (last_win) begin
              o_complete <= 1'b1;
              state      <= S_DONE;
            end else begin
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + ROW_W'(1);
              end else begin
                col <= col + COL_W'(1);
              end
              win_raddr <= nxt_win_raddr;
              tap_raddr <= nxt_win_raddr;
              win_waddr <= win_waddr + ADDR_W'(1);
              state     <= i_stop ? S_PAUSE : S_RD_ISSUE;
            end
          end
          S_PAUSE: begin
            if (!i_stop) state <= S_RD_ISSUE;
          end
          S_IDLE, S_DONE: begin
            state <= state;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef WINDOW_MCU_PERF_EN
  logic busy;
  assign busy = (state != S_IDLE) && (state != S_PAUSE) && (state != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_busy_cycles <= '0;
    end else if (frame_start) begin
      o_busy_cycles <= '0;
    end else if (busy && (o_busy_cycles != 32'hFFFF_FFFF)) begin
      o_busy_cycles <= o_busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_window_mcu.sv
// Directed bench for window_mcu on a 6x5 image with a 3x3 window
// (4x3 windows, 12 results).
module tb_window_mcu;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic        i_stop;
  logic        i_read_complete;
  logic        i_calc_ready;
  logic        i_write_complete;
  logic [31:0] o_raddr;
  logic        o_re;
  logic        o_calc_start;
  logic [31:0] o_waddr;
  logic        o_we;
  logic        o_complete;
`ifdef WINDOW_MCU_PERF_EN
  logic [31:0] o_busy_cycles;
`endif

  // Responders: automatic 1-cycle answers OR'ed with manual overrides.
  logic auto_rd, auto_calc, auto_wr;
  logic man_rd, man_calc, man_wr;
  assign i_read_complete  = (auto_rd & o_re) | man_rd;
  assign i_calc_ready     = (auto_calc & o_calc_start) | man_calc;
  assign i_write_complete = (auto_wr & o_we) | man_wr;

  window_mcu #(
    .IMG_W(6), .IMG_H(5), .WIN(3), .ADDR_W(32),
    .BASE_RADDR(32'd0), .BASE_WADDR(32'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_stop(i_stop),
    .i_read_complete(i_read_complete),
    .i_calc_ready(i_calc_ready),
    .i_write_complete(i_write_complete),
`ifdef WINDOW_MCU_PERF_EN
    .o_busy_cycles(o_busy_cycles),
`endif
    .o_raddr(o_raddr),
    .o_re(o_re),
    .o_calc_start(o_calc_start),
    .o_waddr(o_waddr),
    .o_we(o_we),
    .o_complete(o_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor, sampled on the falling edge.
  int          cyc = 0;
  logic [31:0] rd_q[$];
  logic [31:0] we_q[$];
  int          n_calc = 0;
  int          last_we_cyc = 0;
  int          cmp_rise_cyc = 0;
  logic        cmp_d = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_re) rd_q.push_back(o_raddr);
    if (o_we) begin
      we_q.push_back(o_waddr);
      last_we_cyc = cyc;
    end
    if (o_calc_start) n_calc = n_calc + 1;
    if (o_complete && !cmp_d) cmp_rise_cyc = cyc;
    cmp_d = o_complete;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_re"},       {31'd0, o_re},         32'd0);
    check({tag, "_we"},       {31'd0, o_we},         32'd0);
    check({tag, "_calc"},     {31'd0, o_calc_start}, 32'd0);
    check({tag, "_complete"}, {31'd0, o_complete},   32'd0);
    check({tag, "_raddr"},    o_raddr,               32'd0);
    check({tag, "_waddr"},    o_waddr,               32'd0);
  endtask

  task automatic wait_complete(input int bound);
    for (int k = 0; k < bound && !o_complete; k++) tick;
    check("frame_complete", {31'd0, o_complete}, 32'd1);
  endtask

  int exp_first[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
  int exp_last[9]  = '{15, 16, 17, 21, 22, 23, 27, 28, 29};
  int brd, bwe, bcalc;

  initial begin
    rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    auto_rd = 1'b1; auto_calc = 1'b1; auto_wr = 1'b1;
    man_rd = 1'b0; man_calc = 1'b0; man_wr = 1'b0;
    tick; tick;
    check_outputs_zero("reset");
`ifdef WINDOW_MCU_PERF_EN
    check("reset_busy", o_busy_cycles, 32'd0);
`endif
    rst = 1'b0;
    tick;
    check("idle_no_re", {31'd0, o_re}, 32'd0);

    // Full frame with 1-cycle responders.
    i_start = 1'b1; tick; i_start = 1'b0;
    for (int k = 0; k < 100 && n_calc < 1; k++) tick;
    check("w0_reads_before_calc", rd_q.size(), 32'd9);
    for (int i = 0; i < 9; i++) check("w0_raddr", rd_q[i], exp_first[i]);
    check("w0_no_write_before_calc", we_q.size(), 32'd0);
    for (int k = 0; k < 20 && we_q.size() < 1; k++) tick;
    check("w0_waddr", we_q[0], 32'd0);
    check("w0_one_calc", n_calc, 32'd1);
    wait_complete(1000);
    check("frame_reads", rd_q.size(), 32'd108);
    for (int i = 0; i < 9; i++) check("last_win_raddr", rd_q[99 + i], exp_last[i]);
    check("frame_writes", we_q.size(), 32'd12);
    check("last_waddr", we_q[11], 32'd11);
    check("frame_calcs", n_calc, 32'd12);
    check("complete_after_advance", cmp_rise_cyc - last_we_cyc, 32'd2);
    tick; tick; tick;
    check("complete_held", {31'd0, o_complete}, 32'd1);
    check("done_no_re", {31'd0, o_re}, 32'd0);
`ifdef WINDOW_MCU_PERF_EN
    check("busy_cycles", o_busy_cycles, 32'd276);
`endif

    // Pause during window 4 (result address 4).
    brd = rd_q.size(); bwe = we_q.size();
    i_start = 1'b1; tick; i_start = 1'b0;
    check("restart_clears_complete", {31'd0, o_complete}, 32'd0);
    for (int k = 0; k < 500 && (rd_q.size() - brd) < 38; k++) tick;
    i_stop = 1'b1;
    for (int k = 0; k < 100 && (we_q.size() - bwe) < 5; k++) tick;
    check("restart_first_raddr", rd_q[brd], 32'd0);
    check("stop_window_waddr", we_q[bwe + 4], 32'd4);
    repeat (10) tick;
    check("pause_reads", rd_q.size() - brd, 32'd45);
    check("pause_writes", we_q.size() - bwe, 32'd5);
    check("pause_no_re", {31'd0, o_re}, 32'd0);
    i_stop = 1'b0;
    for (int k = 0; k < 20 && (rd_q.size() - brd) < 46; k++) tick;
    check("resume_raddr", rd_q[brd + 45], 32'd7);
    for (int k = 0; k < 100 && (we_q.size() - bwe) < 6; k++) tick;
    check("resume_waddr", we_q[bwe + 5], 32'd5);
    wait_complete(1000);

    // Held read completion and a stray completion during compute.
    brd = rd_q.size(); bwe = we_q.size(); bcalc = n_calc;
    auto_rd = 1'b0; auto_calc = 1'b0; man_rd = 1'b1;
    i_start = 1'b1; tick; i_start = 1'b0;
    for (int k = 0; k < 30 && (rd_q.size() - brd) < 5; k++) tick;
    man_rd = 1'b0;
    repeat (5) tick;
    check("held_rd_reads", rd_q.size() - brd, 32'd5);
    check("held_rd_tap3", rd_q[brd + 3], 32'd6);
    check("held_rd_tap4", rd_q[brd + 4], 32'd7);
    auto_rd = 1'b1; man_rd = 1'b1; tick; man_rd = 1'b0;
    for (int k = 0; k < 50 && (n_calc - bcalc) < 1; k++) tick;
    man_rd = 1'b1; tick; tick; man_rd = 1'b0;
    check("calc_wait_reads", rd_q.size() - brd, 32'd9);
    check("calc_wait_no_re", {31'd0, o_re}, 32'd0);
    check("calc_wait_no_write", we_q.size() - bwe, 32'd0);
    man_calc = 1'b1; tick; man_calc = 1'b0; auto_calc = 1'b1;
    wait_complete(1000);
    check("held_frame_writes", we_q.size() - bwe, 32'd12);

    // Reset in the read wait of window 2.
    bwe = we_q.size();
    i_start = 1'b1; tick; i_start = 1'b0;
    for (int k = 0; k < 200 && (we_q.size() - bwe) < 2; k++) tick;
    for (int k = 0; k < 20 && !o_re; k++) tick;
    check("rst_taken_in_rd_wait", {31'd0, o_re}, 32'd1);
    rst = 1'b1; tick;
    check_outputs_zero("mid_rst");
    rst = 1'b0;
    brd = rd_q.size(); bwe = we_q.size();
    tick; tick; tick;
    check("post_rst_idle_reads", rd_q.size() - brd, 32'd0);
    check("post_rst_idle_complete", {31'd0, o_complete}, 32'd0);
    i_start = 1'b1; tick; i_start = 1'b0;
    for (int k = 0; k < 20 && (rd_q.size() - brd) < 1; k++) tick;
    check("post_rst_first_raddr", rd_q[brd], 32'd0);
    wait_complete(1000);
    check("post_rst_frame_writes", we_q.size() - bwe, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
